// File: rtl/gpc_share_pkg.sv
// Shared constants and operand packet layout for the shared gpc2135_5 arbiter.
package gpc_share_pkg;

   localparam int unsigned SRC0_W = 5;
   localparam int unsigned SRC1_W = 3;
   localparam int unsigned SRC2_W = 1;
   localparam int unsigned SRC3_W = 2;
   localparam int unsigned PKT_W  = 11;
   localparam int unsigned SUM_W  = 5;

   // Bit order matches the requester packet slice: {src3, src2, src1, src0}
   typedef struct packed {
      logic [SRC3_W-1:0] src3;
      logic [SRC2_W-1:0] src2;
      logic [SRC1_W-1:0] src1;
      logic [SRC0_W-1:0] src0;
   } gpc_pkt_t;

endpackage

// File: rtl/gpc2135_5.sv
// Generalized parallel counter (2,1,3,5;5): weighted popcount of four rank groups.
module gpc2135_5 (
   input  logic [4:0] src0,
   input  logic [2:0] src1,
   input  logic       src2,
   input  logic [1:0] src3,
   output logic [4:0] sum
);

   logic [2:0] cnt0;
   logic [1:0] cnt1;
   logic [1:0] cnt3;

   always_comb begin
      cnt0 = 3'(src0[0]) + 3'(src0[1]) + 3'(src0[2]) + 3'(src0[3]) + 3'(src0[4]);
      cnt1 = 2'(src1[0]) + 2'(src1[1]) + 2'(src1[2]);
      cnt3 = 2'(src3[0]) + 2'(src3[1]);
   end

   // Max 5 + 6 + 4 + 16 = 31, so 5 bits never overflow
   assign sum = 5'(cnt0) + {2'b00, cnt1, 1'b0} + {2'b00, src2, 2'b00} + {cnt3, 3'b000};

endmodule

// File: rtl/gpc_share_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] next_ptr
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (en && !found && req[ID_W'(idx)]) begin
            found            = 1'b1;
            gnt[ID_W'(idx)]  = 1'b1;
            next_ptr         = (idx == NREQ - 1) ? '0 : ID_W'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/gpc_share_arb.sv
// Shares one gpc2135_5 among NREQ requesters via a round-robin grant and a 2-stage pipeline.
// Optional per-requester accumulation of sums is enabled by defining GPC_SHARE_ACC_EN.
module gpc_share_arb
   import gpc_share_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned ID_W  = $clog2(NREQ),
   parameter int unsigned ACC_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*PKT_W-1:0] pkt_i,
   output logic [NREQ-1:0]       ack_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
`ifdef GPC_SHARE_ACC_EN
   input  logic [NREQ-1:0]       acc_clr_i,
   output logic [ACC_W-1:0]      rsp_sum_o
`else
   output logic [SUM_W-1:0]      rsp_sum_o
`endif
);

   if (NREQ < 2 || NREQ > 16 || ACC_W < SUM_W) begin : g_bad_cfg
      $error("gpc_share_arb: unsupported parameter set");
   end

   logic            s1_valid;
   logic [ID_W-1:0] s1_id;
   gpc_pkt_t        s1_pkt;
   logic            s2_valid;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] next_ptr;
   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [ID_W-1:0] gnt_id;
   gpc_pkt_t        gnt_pkt;
   logic [SUM_W-1:0] s1_sum;
   logic            adv1;
   logic            adv2;
   logic            load2;

   // Pipeline advance: S2 frees when empty or consumed, S1 frees when empty or moving on
   assign adv2    = !s2_valid || rsp_ready_i;
   assign adv1    = !s1_valid || adv2;
   assign load2   = adv2 && s1_valid;
   assign gnt_any = |gnt;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req      (req_i),
      .ptr      (ptr),
      .en       (adv1 && rst_n),
      .gnt      (gnt),
      .next_ptr (next_ptr)
   );

   assign ack_o = gnt;

   // One-hot grant to winner index and its packet
   always_comb begin
      gnt_id  = '0;
      gnt_pkt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_id  = ID_W'(i);
            gnt_pkt = gpc_pkt_t'(pkt_i[i*PKT_W +: PKT_W]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_pkt   <= '0;
         ptr      <= '0;
      end else if (gnt_any) begin
         s1_valid <= 1'b1;
         s1_id    <= gnt_id;
         s1_pkt   <= gnt_pkt;
         ptr      <= next_ptr;
      end else if (adv2) begin
         s1_valid <= 1'b0;
      end
   end

   gpc2135_5 u_gpc (
      .src0 (s1_pkt.src0),
      .src1 (s1_pkt.src1),
      .src2 (s1_pkt.src2),
      .src3 (s1_pkt.src3),
      .sum  (s1_sum)
   );

`ifdef GPC_SHARE_ACC_EN
   logic [ACC_W-1:0] acc [NREQ];
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] acc_new;

   // A clear coinciding with an update restarts the total from this sum
   always_comb begin
      acc_base = acc_clr_i[s1_id] ? '0 : acc[s1_id];
      acc_new  = acc_base + ACC_W'(s1_sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NREQ; k++) acc[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (load2 && s1_id == ID_W'(k)) begin
               acc[k] <= acc_new;
            end else if (acc_clr_i[k]) begin
               acc[k] <= '0;
            end
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         rsp_id_o  <= '0;
         rsp_sum_o <= '0;
      end else if (load2) begin
         s2_valid  <= 1'b1;
         rsp_id_o  <= s1_id;
`ifdef GPC_SHARE_ACC_EN
         rsp_sum_o <= acc_new;
`else
         rsp_sum_o <= s1_sum;
`endif
      end else if (rsp_ready_i) begin
         s2_valid  <= 1'b0;
      end
   end

   assign rsp_valid_o = s2_valid;

endmodule

// File: tb/tb_gpc_share_arb.sv
// Randomized and directed bench for gpc_share_arb against a two-slot queue reference model.
module tb_gpc_share_arb;
   import gpc_share_pkg::*;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned ID_W  = 2;
   localparam int unsigned ACC_W = 12;
`ifdef GPC_SHARE_ACC_EN
   localparam int unsigned RW = ACC_W;
`else
   localparam int unsigned RW = SUM_W;
`endif

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_i;
   logic [NREQ*PKT_W-1:0] pkt_i;
   logic [NREQ-1:0]       ack_o;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [ID_W-1:0]       rsp_id_o;
   logic [RW-1:0]         rsp_sum_o;
   logic [NREQ-1:0]       acc_clr_i;

   gpc_share_arb #(
      .NREQ  (NREQ),
      .ID_W  (ID_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .pkt_i       (pkt_i),
      .ack_o       (ack_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_id_o    (rsp_id_o),
`ifdef GPC_SHARE_ACC_EN
      .acc_clr_i   (acc_clr_i),
`endif
      .rsp_sum_o   (rsp_sum_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: in-flight packets in grant order; capacity two, front shown once loaded
   typedef struct {
      int id;
      int raw;
      int sum;
      int age;
      bit loaded;
   } ent_t;

   ent_t            pipe[$];
   int              m_ptr;
   int              m_acc[NREQ];
   logic [NREQ-1:0] last_ack;
   logic [NREQ-1:0] obs_ack;
   bit              keep_req;

   function automatic int gpc_sum(input logic [10:0] p);
      return $countones(p[4:0]) + 2 * $countones(p[7:5]) + 4 * int'(p[8]) + 8 * $countones(p[10:9]);
   endfunction

   task automatic set_pkt(input int i, input logic [10:0] v);
      pkt_i[i*PKT_W +: PKT_W] = v;
   endtask

   task automatic model_clear();
      pipe.delete();
      m_ptr = 0;
      for (int k = 0; k < NREQ; k++) m_acc[k] = 0;
   endtask

   task automatic cycle();
      bit              exp_valid;
      bit              can;
      bit              rdy;
      int              win;
      int              idx;
      logic [NREQ-1:0] exp_ack;
      logic [NREQ-1:0] clr;
      logic [10:0]     wpkt;
      ent_t            e;
      @(negedge clk);
      exp_valid = pipe.size() > 0 && pipe[0].loaded;
      check("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
      if (exp_valid) begin
         check("rsp_id", 32'(rsp_id_o), 32'(pipe[0].id));
         check("rsp_sum", 32'(rsp_sum_o), 32'(pipe[0].sum));
      end
      rdy  = rsp_ready_i;
      clr  = acc_clr_i;
      can  = pipe.size() < 2 || rdy;
      win  = -1;
      if (can) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && req_i[idx]) win = idx;
         end
      end
      exp_ack = (win >= 0) ? NREQ'(1 << win) : '0;
      check("ack", 32'(ack_o), 32'(exp_ack));
      obs_ack  = ack_o;
      last_ack = exp_ack;
      wpkt     = '0;
      if (win >= 0) wpkt = pkt_i[win*PKT_W +: PKT_W];
      @(posedge clk);
      if (exp_valid && rdy) void'(pipe.pop_front());
      if (pipe.size() > 0 && !pipe[0].loaded && pipe[0].age >= 1) begin
         pipe[0].loaded = 1'b1;
`ifdef GPC_SHARE_ACC_EN
         m_acc[pipe[0].id] = ((clr[pipe[0].id] ? 0 : m_acc[pipe[0].id]) + pipe[0].raw) % (1 << ACC_W);
         pipe[0].sum = m_acc[pipe[0].id];
         for (int k = 0; k < NREQ; k++) if (clr[k] && k != pipe[0].id) m_acc[k] = 0;
      end else begin
         for (int k = 0; k < NREQ; k++) if (clr[k]) m_acc[k] = 0;
`endif
      end
      foreach (pipe[i]) pipe[i].age++;
      if (win >= 0) begin
         e.id = win; e.raw = gpc_sum(wpkt); e.sum = e.raw; e.age = 1; e.loaded = 1'b0;
         pipe.push_back(e);
         m_ptr = (win + 1) % NREQ;
      end
      #1;
   endtask

   task automatic step();
      cycle();
      if (!keep_req) req_i = req_i & ~last_ack;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_ack", 32'(ack_o), 32'h0);
      check("rst_valid", 32'(rsp_valid_o), 32'h0);
      check("rst_id", 32'(rsp_id_o), 32'h0);
      check("rst_sum", 32'(rsp_sum_o), 32'h0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      req_i = '0;
      rsp_ready_i = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      int n;
      rst_n = 1'b1; req_i = '0; pkt_i = '0; rsp_ready_i = 1'b1; acc_clr_i = '0; keep_req = 1'b0;
      model_clear();
      #2;
      do_reset();

      // Single request: expected sum 5'h17 two cycles after ack
      set_pkt(0, {2'h3, 1'b1, 3'h2, 5'h10});
      req_i = 4'b0001;
      step();
      step();
      check("single_valid", 32'(rsp_valid_o), 32'h1);
      check("single_id", 32'(rsp_id_o), 32'h0);
      check("single_sum", 32'(rsp_sum_o), 32'h17);
      drain();

      // Continuous requests from all, with all-ones and all-zero extremes
      set_pkt(0, 11'h7ff);
      set_pkt(1, 11'h000);
      set_pkt(2, 11'($urandom));
      set_pkt(3, 11'($urandom));
      keep_req = 1'b1;
      req_i = '1;
      repeat (12) begin
         step();
`ifndef GPC_SHARE_ACC_EN
         if (rsp_valid_o && rsp_id_o == 2'd0) check("ext_ones", 32'(rsp_sum_o), 32'h1f);
         if (rsp_valid_o && rsp_id_o == 2'd1) check("ext_zero", 32'(rsp_sum_o), 32'h00);
`endif
      end
      keep_req = 1'b0;
      drain();

      // Backpressure: two packets absorbed, then no further ack until release
      rsp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) set_pkt(i, 11'($urandom));
      req_i = 4'b0111;
      n = 0;
      repeat (6) begin
         step();
         n += $countones(obs_ack);
      end
      check("bp_acks", 32'(n), 32'd2);
      rsp_ready_i = 1'b1;
      repeat (6) step();
      drain();

      // Wrap: with ptr at 2, requester 3 wins before requester 1
      req_i = 4'b0010;
      step();
      req_i = 4'b1010;
      step();
      check("rr_first", 32'(obs_ack), 32'b1000);
      step();
      check("rr_second", 32'(obs_ack), 32'b0010);
      drain();

      // Reset between ack and response discards the packet
      req_i = 4'b0100;
      step();
      req_i = 4'b0101;
      do_reset();
      step();
      check("rst_first_gnt", 32'(obs_ack), 32'b0001);
      drain();

`ifdef GPC_SHARE_ACC_EN
      // Accumulation for requester 2, then clear coinciding with an update
      do_reset();
      set_pkt(2, {2'h3, 1'b1, 3'h2, 5'h10});
      req_i = 4'b0100;
      step();
      set_pkt(2, 11'h7ff);
      req_i = 4'b0100;
      step();
      check("acc_first", 32'(rsp_sum_o), 32'd23);
      step();
      check("acc_second", 32'(rsp_sum_o), 32'd54);
      drain();
      set_pkt(2, {2'h0, 1'b0, 3'h0, 5'h1f});
      req_i = 4'b0100;
      step();
      acc_clr_i = 4'b0100;
      step();
      acc_clr_i = '0;
      check("acc_clr_upd", 32'(rsp_sum_o), 32'd5);
      drain();
`endif

      // Randomized traffic with random backpressure and legal request drops
      for (int c = 0; c < 1500; c++) begin
         rsp_ready_i = ($urandom % 4) != 0;
`ifdef GPC_SHARE_ACC_EN
         acc_clr_i = (($urandom % 8) == 0) ? NREQ'($urandom) : '0;
`endif
         cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (last_ack[i]) begin
               req_i[i] = $urandom % 2;
               set_pkt(i, 11'($urandom));
            end else if (req_i[i] && ($urandom % 16) == 0) begin
               req_i[i] = 1'b0;
            end else if (!req_i[i] && ($urandom % 3) == 0) begin
               req_i[i] = 1'b1;
               set_pkt(i, 11'($urandom));
            end
         end
      end
      acc_clr_i = '0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
